// File: rtl/bisr_pkg.sv
// Purpose : shared definitions for the built-in self-repair schedulers.
// Latency : n/a (types and constant helpers only).
// Backpr. : n/a.
// Contents: state_t (IDLE/DRAIN/APPLY/DONE/FAIL) and clog2_min1(), a width helper that never returns 0.
package bisr_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_DRAIN = 3'd1,
    ST_APPLY = 3'd2,
    ST_DONE  = 3'd3,
    ST_FAIL  = 3'd4
  } state_t;

  // Width of an index over n items; at least 1 bit so a 1-entry index is still a legal vector.
  function automatic int clog2_min1(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/fault_col_encoder.sv
// Purpose : turns a per-column fault map into the shift target (lowest faulty column and all above it).
// Latency : combinational, zero cycles.
// Backpr. : none; pure function of the input.
// Ports   : i_fault_map [NUM_COLS] in, o_target [NUM_COLS] out, o_multi_fault out (more than one bit set).
module fault_col_encoder
  import bisr_pkg::*;
#(
  parameter int NUM_COLS = 4
) (
  input  logic [NUM_COLS-1:0] i_fault_map,
  output logic [NUM_COLS-1:0] o_target,
  output logic                o_multi_fault
);

  logic [NUM_COLS-1:0] w_target;
  logic                w_seen;
  logic                w_multi;

  // Scan upwards: once the first fault is seen every later column is shifted.
  // A second fault while already shifting is more than one spare can cover.
  always_comb begin
    w_target = '0;
    w_seen   = 1'b0;
    w_multi  = 1'b0;
    for (int i = 0; i < NUM_COLS; i++) begin
      if (i_fault_map[i]) begin
        if (w_seen) w_multi = 1'b1;
        w_seen = 1'b1;
      end
      w_target[i] = w_seen;
    end
  end

  assign o_target      = w_target;
  assign o_multi_fault = w_multi;

endmodule

// File: rtl/shift_en_scheduler.sv
// Purpose : drains the PE array, then rolls the new shift_en pattern out one column per cycle.
// Latency : strobe at edge t -> shift_en[k] at edge t+DRAIN_CYCLES+1+k, repair_done in cycle t+DRAIN_CYCLES+NUM_COLS+1.
// Backpr. : hold_input stalls the feeders from DRAIN through DONE; strobes outside IDLE are dropped.
// Ports   : clk, rst (async, active-high), fault_valid/fault_map from BIST, array_busy from the datapath;
//           shift_en to the stall registers, hold_input, repair_busy, repair_done (pulse), unrepairable (sticky).
module shift_en_scheduler
  import bisr_pkg::*;
#(
  parameter int NUM_COLS     = 4,
  parameter int DRAIN_CYCLES = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                fault_valid,
  input  logic [NUM_COLS-1:0] fault_map,
  input  logic                array_busy,
  output logic [NUM_COLS-1:0] shift_en,
  output logic                hold_input,
  output logic                repair_busy,
  output logic                repair_done,
  output logic                unrepairable
);

  localparam int CNT_W = $clog2(DRAIN_CYCLES + 1);
  localparam int IDX_W = clog2_min1(NUM_COLS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DRAIN_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_COLS - 1);

  logic [NUM_COLS-1:0] w_target;
  logic                w_multi_fault;

  state_t              r_state;
  logic [NUM_COLS-1:0] r_target;
  logic [CNT_W-1:0]    r_cnt;
  logic [IDX_W-1:0]    r_col;
  logic [NUM_COLS-1:0] r_shift;
  logic                r_hold;
  logic                r_busy;
  logic                r_done;
  logic                r_unrep;

  fault_col_encoder #(
    .NUM_COLS(NUM_COLS)
  ) u_enc (
    .i_fault_map  (fault_map),
    .o_target     (w_target),
    .o_multi_fault(w_multi_fault)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_target <= '0;
      r_cnt    <= '0;
      r_col    <= '0;
      r_shift  <= '0;
      r_hold   <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_unrep  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (fault_valid) begin
            if (w_multi_fault) begin
              r_state <= ST_FAIL;
              r_unrep <= 1'b1;
            end else begin
              r_target <= w_target;
              r_cnt    <= '0;
              r_hold   <= 1'b1;
              r_busy   <= 1'b1;
              r_state  <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          // Needs DRAIN_CYCLES back-to-back idle cycles; any busy cycle restarts the count.
          if (array_busy) begin
            r_cnt <= '0;
          end else if (r_cnt == CNT_LAST) begin
            r_cnt   <= '0;
            r_col   <= '0;
            r_state <= ST_APPLY;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_APPLY: begin
          // One column per cycle, lowest first, so the proxy path fills in order.
          r_shift[r_col] <= r_target[r_col];
          if (r_col == IDX_LAST) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end else begin
            r_col <= r_col + IDX_W'(1);
          end
        end
        ST_DONE: begin
          r_hold  <= 1'b0;
          r_state <= ST_IDLE;
        end
        ST_FAIL: begin
          r_state <= ST_FAIL;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign shift_en     = r_shift;
  assign hold_input   = r_hold;
  assign repair_busy  = r_busy;
  assign repair_done  = r_done;
  assign unrepairable = r_unrep;

endmodule
